// File: rtl/pattern_source.sv
// Programmable pattern source: emits bursts of N words (hold/rotate/LFSR/increment) feeding the inverter bank.
// Latency: first word valid the cycle after an accepted start; done pulses the cycle after the last handshake.
// Backpressure: while out_valid & !out_ready, out_data, pattern and remaining hold stable.
module pattern_source #(
   parameter int unsigned          WIDTH = 8,
   parameter logic [WIDTH-1:0]     SEED  = 8'hAA,
   parameter logic [WIDTH-1:0]     TAPS  = 8'hB8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load_data,
   input  logic [1:0]       mode,
   input  logic             start,
   input  logic [7:0]       num_words,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0] M_HOLD = 2'b00;
   localparam logic [1:0] M_ROT  = 2'b01;
   localparam logic [1:0] M_LFSR = 2'b10;
   localparam logic [1:0] M_INC  = 2'b11;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pattern_q, pattern_d;
   logic [7:0]       remaining_q, remaining_d;
   logic [1:0]       mode_q, mode_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] next_pattern;

   // Next-pattern rule selected by the mode latched at start; all-zero LFSR state escapes to SEED.
   always_comb begin
      next_pattern = pattern_q;
      case (mode_q)
         M_HOLD: next_pattern = pattern_q;
         M_ROT:  next_pattern = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
         M_LFSR: begin
            if (pattern_q == '0)
               next_pattern = SEED;
            else
               next_pattern = {pattern_q[WIDTH-2:0], ^(pattern_q & TAPS)};
         end
         M_INC:  next_pattern = pattern_q + WIDTH'(1);
         default: next_pattern = pattern_q;
      endcase
   end

   // FSM next-state and datapath updates; outputs are decoded from the next state so they register cleanly.
   always_comb begin
      state_d     = state_q;
      pattern_d   = pattern_q;
      remaining_d = remaining_q;
      mode_d      = mode_q;
      case (state_q)
         S_IDLE: begin
            // A load in the same cycle as start wins, so the first word is load_data.
            if (load_en)
               pattern_d = load_data;
            if (start) begin
               mode_d      = mode;
               remaining_d = num_words;
               state_d     = (num_words == 8'd0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (out_valid_q && out_ready) begin
               pattern_d   = next_pattern;
               remaining_d = remaining_q - 8'd1;
               if (remaining_q == 8'd1)
                  state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      out_valid_d = (state_d == S_RUN);
      busy_d      = (state_d == S_RUN);
      done_d      = (state_d == S_DONE);
   end

   // All state and registered outputs; synchronous reset aborts any burst without a done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         pattern_q   <= SEED;
         remaining_q <= 8'd0;
         mode_q      <= 2'b00;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pattern_q   <= pattern_d;
         remaining_q <= remaining_d;
         mode_q      <= mode_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign out_data  = pattern_q;

endmodule

// File: tb/tb_pattern_source.sv
// Directed bench for pattern_source: hand-computed words for each mode, backpressure, reset abort and start masking.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// The downstream inverter bank is modelled as ~out_data.
module tb_pattern_source;

   logic       clk = 1'b0;
   logic       reset;
   logic       load_en;
   logic [7:0] load_data;
   logic [1:0] mode;
   logic       start;
   logic [7:0] num_words;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       busy;
   logic       done;
   logic [7:0] bank_out;

   int n_cmp = 0;
   int n_err = 0;

   pattern_source #(.WIDTH(8), .SEED(8'hAA), .TAPS(8'hB8)) dut (
      .clk       (clk),
      .reset     (reset),
      .load_en   (load_en),
      .load_data (load_data),
      .mode      (mode),
      .start     (start),
      .num_words (num_words),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .done      (done)
   );

   assign bank_out = ~out_data;

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Checks an active word: valid, busy, data, bank output, no done.
   task automatic chk_word(input string tag, input logic [7:0] exp);
      chk({tag, ".valid"}, {7'd0, out_valid}, 8'd1);
      chk({tag, ".busy"},  {7'd0, busy},      8'd1);
      chk({tag, ".data"},  out_data,          exp);
      chk({tag, ".bank"},  bank_out,          ~exp);
      chk({tag, ".done"},  {7'd0, done},      8'd0);
   endtask

   task automatic chk_done(input string tag);
      chk({tag, ".done"},  {7'd0, done},      8'd1);
      chk({tag, ".valid"}, {7'd0, out_valid}, 8'd0);
      chk({tag, ".busy"},  {7'd0, busy},      8'd0);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".done"},  {7'd0, done},      8'd0);
      chk({tag, ".valid"}, {7'd0, out_valid}, 8'd0);
      chk({tag, ".busy"},  {7'd0, busy},      8'd0);
   endtask

   task automatic go(input logic ld, input logic [7:0] ld_val, input logic [1:0] m, input logic [7:0] n);
      load_en   = ld;
      load_data = ld_val;
      mode      = m;
      num_words = n;
      start     = 1'b1;
      tick();
      load_en   = 1'b0;
      start     = 1'b0;
   endtask

   initial begin
      reset = 1'b1; load_en = 1'b0; load_data = 8'h00; mode = 2'b00;
      start = 1'b0; num_words = 8'd0; out_ready = 1'b1;
      tick(); tick();
      reset = 1'b0;
      chk_idle("reset");
      chk("reset.data", out_data, 8'hAA);

      // Rotate burst from SEED
      go(1'b0, 8'h00, 2'b01, 8'd3);
      chk_word("rot0", 8'hAA); tick();
      chk_word("rot1", 8'h55); tick();
      chk_word("rot2", 8'hAA); tick();
      chk_done("rot.end"); tick();
      chk_idle("rot.idle");

      // LFSR from AA
      go(1'b1, 8'hAA, 2'b10, 8'd2);
      chk_word("lfsr0", 8'hAA); tick();
      chk_word("lfsr1", 8'h55); tick();
      chk_done("lfsr.end"); tick();

      // LFSR lock-up escape
      go(1'b1, 8'h00, 2'b10, 8'd2);
      chk_word("lfz0", 8'h00); tick();
      chk_word("lfz1", 8'hAA); tick();
      chk_done("lfz.end"); tick();

      // Increment wrap, then continuation without load
      go(1'b1, 8'hFE, 2'b11, 8'd3);
      chk_word("inc0", 8'hFE); tick();
      chk_word("inc1", 8'hFF); tick();
      chk_word("inc2", 8'h00); tick();
      chk_done("inc.end"); tick();
      go(1'b0, 8'h00, 2'b11, 8'd1);
      chk_word("cont0", 8'h01); tick();
      chk_done("cont.end"); tick();
      chk_idle("cont.idle");

      // Backpressure: ready low for 3 cycles after valid rises
      out_ready = 1'b0;
      go(1'b1, 8'hAA, 2'b01, 8'd2);
      chk_word("bp.hold0", 8'hAA); tick();
      chk_word("bp.hold1", 8'hAA); tick();
      chk_word("bp.hold2", 8'hAA); tick();
      out_ready = 1'b1;
      chk_word("bp0", 8'hAA); tick();
      chk_word("bp1", 8'h55); tick();
      chk_done("bp.end"); tick();
      chk_idle("bp.idle"); tick();
      chk_idle("bp.idle2");

      // Zero-length burst
      go(1'b0, 8'h00, 2'b01, 8'd0);
      chk_done("zero.end"); tick();
      chk_idle("zero.idle");

      // Reset during word 2 of 5
      go(1'b1, 8'h3C, 2'b01, 8'd5);
      chk_word("rst0", 8'h3C); tick();
      chk_word("rst1", 8'h78);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_idle("rst.abort");
      chk("rst.data", out_data, 8'hAA);
      tick();
      chk_idle("rst.after");
      chk("rst.data2", out_data, 8'hAA);

      // start held through RUN and DONE
      go(1'b1, 8'h10, 2'b11, 8'd2);
      start = 1'b1;
      chk_word("hold0", 8'h10); tick();
      chk_word("hold1", 8'h11); tick();
      chk_done("hold.end"); tick();
      chk_idle("hold.idle"); tick();
      start = 1'b0;
      chk_word("hold.re0", 8'h12); tick();
      chk_word("hold.re1", 8'h13); tick();
      chk_done("hold.re.end"); tick();
      chk_idle("hold.re.idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
